counter_seq_checker: RTL

Passive checker on the output bus of the free-running up-counter (the 4-bit ripple counter and its family). It samples the counter value every rising clock edge and locks onto the increment sequence. Once locked, it flags every sample that breaks the modulo-2^WIDTH +1 sequence, counts the errors, and reports correct wrap-arounds. It is instantiated beside the counter in benches and in self-checking top levels.

---
 rtl/counter_seq_checker.sv | 138 +++++++++++++
 1 files changed

// File: rtl/counter_seq_checker.sv
// counter_seq_checker: passive monitor that locks onto a modulo-2^WIDTH
// up-count on q, then flags breaks in the sequence, counts them and reports wraps.
module counter_seq_checker #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned LOCK_LEN = 3,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] q,
  input  logic             en,
  output logic             locked,
  output logic [WIDTH-1:0] expected,
  output logic             mismatch,
  output logic             wrap,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned      CNT_W    = 4;
  localparam logic [CNT_W-1:0] LOCK_CNT = CNT_W'(LOCK_LEN);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  typedef enum logic {
    ST_ACQUIRE = 1'b0,
    ST_LOCKED  = 1'b1
  } state_t;

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] prev_q,      prev_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic             en_prev_q,   en_prev_d;
  logic             locked_q,    locked_d;
  logic [WIDTH-1:0] expected_q,  expected_d;
  logic             mismatch_q,  mismatch_d;
  logic             wrap_q,      wrap_d;
  logic [ERR_W-1:0] err_q,       err_d;

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] prev_next;
  logic [CNT_W-1:0] cnt_inc;

  // Modulo-2^WIDTH successors and the incremented run length
  assign q_next    = q + WIDTH'(1);
  assign prev_next = prev_q + WIDTH'(1);
  assign cnt_inc   = match_cnt_q + CNT_W'(1);

  // Next-state and output decision for the sample taken at this edge
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    match_cnt_d = match_cnt_q;
    en_prev_d   = en;
    locked_d    = locked_q;
    expected_d  = expected_q;
    mismatch_d  = 1'b0;
    wrap_d      = 1'b0;
    err_d       = err_q;

    if (en) begin
      if (!en_prev_q) begin
        // First edge after a disabled period only seeds the tracker
        state_d     = ST_ACQUIRE;
        locked_d    = 1'b0;
        prev_d      = q;
        match_cnt_d = '0;
      end else begin
        unique case (state_q)
          ST_ACQUIRE: begin
            prev_d = q;
            if (q == prev_next) begin
              if (cnt_inc == LOCK_CNT) begin
                state_d     = ST_LOCKED;
                locked_d    = 1'b1;
                expected_d  = q_next;
                match_cnt_d = '0;
              end else begin
                match_cnt_d = cnt_inc;
              end
            end else begin
              match_cnt_d = '0;
            end
          end
          ST_LOCKED: begin
            prev_d = q;
            if (q == expected_q) begin
              expected_d = q_next;
              wrap_d     = (q == '0);
            end else begin
              // The breaking sample becomes the seed for re-acquisition
              mismatch_d  = 1'b1;
              if (err_q != ERR_MAX) begin
                err_d = err_q + ERR_W'(1);
              end
              locked_d    = 1'b0;
              state_d     = ST_ACQUIRE;
              match_cnt_d = '0;
            end
          end
          default: begin
            state_d = ST_ACQUIRE;
          end
        endcase
      end
    end
  end

  // State and output registers; en_prev starts high so reset itself seeds with prev=0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_ACQUIRE;
      prev_q      <= '0;
      match_cnt_q <= '0;
      en_prev_q   <= 1'b1;
      locked_q    <= 1'b0;
      expected_q  <= '0;
      mismatch_q  <= 1'b0;
      wrap_q      <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      match_cnt_q <= match_cnt_d;
      en_prev_q   <= en_prev_d;
      locked_q    <= locked_d;
      expected_q  <= expected_d;
      mismatch_q  <= mismatch_d;
      wrap_q      <= wrap_d;
      err_q       <= err_d;
    end
  end

  assign locked    = locked_q;
  assign expected  = expected_q;
  assign mismatch  = mismatch_q;
  assign wrap      = wrap_q;
  assign err_count = err_q;

endmodule
